// File: rtl/lc3_mem_arb_pkg.sv
// Shared types and constants for the LC-3 memory arbiter.
//   state_e    : sequencer states (IDLE / ACCESS / RESP)
//   GRANT_*    : one-hot owner encodings on the grant bus
//   CNT_W      : width of the access-latency down-counter
package lc3_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CPU  = 2'b01;
  localparam logic [1:0] GRANT_DBG  = 2'b10;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/lc3_rr_arb2.sv
// Combinational two-way winner pick for the LC-3 memory arbiter.
//   req[0]     : CPU request
//   req[1]     : debug request
//   last_grant : owner of the previous access (GRANT_* encoding)
//   win        : one-hot winner (GRANT_* encoding), GRANT_NONE if no request
// DBG_PRIO=1 gives debug every tie; otherwise ties go to the port
// opposite last_grant.
module lc3_rr_arb2
  import lc3_mem_arb_pkg::*;
#(
  parameter int unsigned DBG_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] win
);

  always_comb begin
    win = GRANT_NONE;
    if (req == 2'b01) begin
      win = GRANT_CPU;
    end else if (req == 2'b10) begin
      win = GRANT_DBG;
    end else if (req == 2'b11) begin
      if (DBG_PRIO != 0) begin
        win = GRANT_DBG;
      end else if (last_grant == GRANT_DBG) begin
        win = GRANT_CPU;
      end else begin
        win = GRANT_DBG;
      end
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Two-port arbiter and access sequencer for the single LC-3 memory array.
//   clk, rst                 : clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata    : CPU access request, held until cpu_ready
//   cpu_ready, cpu_rdata     : one-cycle completion pulse, registered read data
//   dbg_req/we/addr/wdata    : debug/loader access request, held until dbg_ready
//   dbg_ready, dbg_rdata     : one-cycle completion pulse, registered read data
//   mem_en/we/addr/wdata     : memory strobes, held for MEM_LAT cycles per access
//   mem_rdata                : memory read data, valid in the last mem_en cycle
//   grant                    : one-hot owner (01 CPU, 10 debug, 00 none)
// A request sampled in IDLE is latched into the mem_* registers, held for
// MEM_LAT cycles (ACCESS), then the owner gets a one-cycle ready (RESP).
module lc3_mem_arbiter
  import lc3_mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 2,
  parameter int unsigned DBG_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [15:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_ready,
  output logic [15:0] dbg_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  grant
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         last_grant_q, last_grant_d;
  logic [1:0]         grant_q, grant_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic [15:0]        mem_wdata_q, mem_wdata_d;
  logic               cpu_ready_q, cpu_ready_d;
  logic               dbg_ready_q, dbg_ready_d;
  logic [15:0]        cpu_rdata_q, cpu_rdata_d;
  logic [15:0]        dbg_rdata_q, dbg_rdata_d;
  logic [1:0]         win;

  lc3_rr_arb2 #(
    .DBG_PRIO(DBG_PRIO)
  ) u_pick (
    .req       ({dbg_req, cpu_req}),
    .last_grant(last_grant_q),
    .win       (win)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_ready_d  = 1'b0;
    dbg_ready_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (win != GRANT_NONE) begin
          // The mem_* registers double as the request latch, so inputs
          // changing during ACCESS cannot disturb the access.
          grant_d      = win;
          last_grant_d = win;
          mem_en_d     = 1'b1;
          cnt_d        = CNT_LOAD;
          state_d      = ACCESS;
          if (win == GRANT_CPU) begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end else begin
            mem_we_d    = dbg_we;
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = RESP;
          if (grant_q == GRANT_CPU) begin
            cpu_rdata_d = mem_rdata;
            cpu_ready_d = 1'b1;
          end else begin
            dbg_rdata_d = mem_rdata;
            dbg_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        grant_d = GRANT_NONE;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= GRANT_DBG;
      grant_q      <= GRANT_NONE;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ready_q  <= 1'b0;
      dbg_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ready_q  <= cpu_ready_d;
      dbg_ready_q  <= dbg_ready_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_ready = dbg_ready_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter. Three instances share clk/rst:
//   0: MEM_LAT=2, DBG_PRIO=0   1: MEM_LAT=2, DBG_PRIO=1   2: MEM_LAT=1, DBG_PRIO=0
// Each has its own sparse memory model; completions are checked against a
// scoreboard of expected (port, read data) entries.
module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req [3];
  logic        cpu_we [3];
  logic [15:0] cpu_addr [3];
  logic [15:0] cpu_wdata [3];
  logic        cpu_ready [3];
  logic [15:0] cpu_rdata [3];
  logic        dbg_req [3];
  logic        dbg_we [3];
  logic [15:0] dbg_addr [3];
  logic [15:0] dbg_wdata [3];
  logic        dbg_ready [3];
  logic [15:0] dbg_rdata [3];
  logic        mem_en [3];
  logic        mem_we [3];
  logic [15:0] mem_addr [3];
  logic [15:0] mem_wdata [3];
  logic [15:0] mem_rdata [3];
  logic [1:0]  grant [3];

  logic [15:0] mem [3][256];
  logic        hold_cpu [3];
  logic        hold_dbg [3];

  typedef struct {
    int          inst;
    logic        dbg;
    logic        chkd;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int passed = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] idx(logic [15:0] a);
    return {a[15:12], a[3:0]};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    lc3_mem_arbiter #(
      .MEM_LAT ((k == 2) ? 1 : 2),
      .DBG_PRIO((k == 1) ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .cpu_req  (cpu_req[k]),
      .cpu_we   (cpu_we[k]),
      .cpu_addr (cpu_addr[k]),
      .cpu_wdata(cpu_wdata[k]),
      .cpu_ready(cpu_ready[k]),
      .cpu_rdata(cpu_rdata[k]),
      .dbg_req  (dbg_req[k]),
      .dbg_we   (dbg_we[k]),
      .dbg_addr (dbg_addr[k]),
      .dbg_wdata(dbg_wdata[k]),
      .dbg_ready(dbg_ready[k]),
      .dbg_rdata(dbg_rdata[k]),
      .mem_en   (mem_en[k]),
      .mem_we   (mem_we[k]),
      .mem_addr (mem_addr[k]),
      .mem_wdata(mem_wdata[k]),
      .mem_rdata(mem_rdata[k]),
      .grant    (grant[k])
    );
    assign mem_rdata[k] = mem[k][idx(mem_addr[k])];
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int pending(int k);
    int n = 0;
    foreach (sb[i]) if (sb[i].inst == k) n++;
    return n;
  endfunction

  task automatic pop_check(int k, logic dbg, logic [15:0] data);
    int hit = -1;
    foreach (sb[i]) if (hit < 0 && sb[i].inst == k) hit = i;
    chk($sformatf("sb_expected_ready[%0d]", k), 32'(hit >= 0), 1);
    if (hit >= 0) begin
      chk($sformatf("sb_port[%0d]", k), 32'(dbg), 32'(sb[hit].dbg));
      if (sb[hit].chkd) chk($sformatf("sb_rdata[%0d]", k), 32'(data), 32'(sb[hit].data));
      sb.delete(hit);
    end
  endtask

  task automatic push(int k, logic dbg, logic chkd, logic [15:0] data);
    exp_t e;
    e.inst = k; e.dbg = dbg; e.chkd = chkd; e.data = data;
    sb.push_back(e);
  endtask

  // Advance one clock: commit memory writes seen before the edge, then sample
  // 1 time unit after the edge and score any ready pulses.
  task automatic step();
    logic        wr [3];
    logic [15:0] wa [3];
    logic [15:0] wd [3];
    for (int k = 0; k < 3; k++) begin
      wr[k] = mem_en[k] && mem_we[k];
      wa[k] = mem_addr[k];
      wd[k] = mem_wdata[k];
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) if (wr[k]) mem[k][idx(wa[k])] = wd[k];
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (cpu_ready[k]) begin
        pop_check(k, 1'b0, cpu_rdata[k]);
        if (!hold_cpu[k]) cpu_req[k] = 1'b0;
      end
      if (dbg_ready[k]) begin
        pop_check(k, 1'b1, dbg_rdata[k]);
        if (!hold_dbg[k]) dbg_req[k] = 1'b0;
      end
    end
  endtask

  task automatic wait_ready(int k, int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(cpu_ready[k] || dbg_ready[k]) && n < budget);
    chk($sformatf("ready_seen[%0d]", k), 32'(cpu_ready[k] || dbg_ready[k]), 1);
  endtask

  task automatic drain(int k, int budget);
    int n = 0;
    while (pending(k) != 0 && n < budget) begin
      step();
      n++;
    end
    chk($sformatf("drain_left[%0d]", k), pending(k), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int t_prev;
    for (int k = 0; k < 3; k++) begin
      cpu_req[k] = 0; cpu_we[k] = 0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
      dbg_req[k] = 0; dbg_we[k] = 0; dbg_addr[k] = '0; dbg_wdata[k] = '0;
      hold_cpu[k] = 0; hold_dbg[k] = 0;
      for (int a = 0; a < 256; a++) mem[k][a] = '0;
    end
    mem[0][idx(16'h3000)] = 16'h1234;
    mem[1][idx(16'h3000)] = 16'h1234;
    mem[1][idx(16'h4000)] = 16'h5555;

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_mem_en[%0d]", k), 32'(mem_en[k]), 0);
      chk($sformatf("rst_grant[%0d]", k), 32'(grant[k]), 0);
      chk($sformatf("rst_ready[%0d]", k), 32'({cpu_ready[k], dbg_ready[k]}), 0);
    end
    rst = 1'b0;

    // CPU read of 0x3000 on instance 0.
    push(0, 1'b0, 1'b1, 16'h1234);
    cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 16'h3000;
    step();
    chk("rd_c1_mem_en", 32'(mem_en[0]), 1);
    chk("rd_c1_addr", 32'(mem_addr[0]), 32'h3000);
    chk("rd_c1_we", 32'(mem_we[0]), 0);
    chk("rd_c1_grant", 32'(grant[0]), 32'h1);
    step();
    chk("rd_c2_mem_en", 32'(mem_en[0]), 1);
    chk("rd_c2_ready", 32'(cpu_ready[0]), 0);
    step();
    chk("rd_c3_ready", 32'(cpu_ready[0]), 1);
    chk("rd_c3_dbg_ready", 32'(dbg_ready[0]), 0);
    chk("rd_c3_mem_en", 32'(mem_en[0]), 0);
    chk("rd_c3_grant", 32'(grant[0]), 32'h1);
    step();
    chk("rd_c4_ready", 32'(cpu_ready[0]), 0);
    chk("rd_c4_grant", 32'(grant[0]), 0);
    chk("rd_c4_rdata_held", 32'(cpu_rdata[0]), 32'h1234);

    // Debug write 0xBEEF to 0x4000, then CPU reads it back.
    push(0, 1'b1, 1'b0, 16'h0000);
    dbg_req[0] = 1; dbg_we[0] = 1; dbg_addr[0] = 16'h4000; dbg_wdata[0] = 16'hBEEF;
    step();
    chk("wr_c1_we", 32'({mem_en[0], mem_we[0]}), 32'h3);
    chk("wr_c1_addr", 32'(mem_addr[0]), 32'h4000);
    chk("wr_c1_wdata", 32'(mem_wdata[0]), 32'hBEEF);
    chk("wr_c1_grant", 32'(grant[0]), 32'h2);
    step();
    chk("wr_c2_we", 32'({mem_en[0], mem_we[0]}), 32'h3);
    step();
    chk("wr_c3_dbg_ready", 32'(dbg_ready[0]), 1);
    chk("wr_c3_mem_we", 32'({mem_en[0], mem_we[0]}), 0);
    step();
    chk("wr_c4_dbg_ready", 32'(dbg_ready[0]), 0);
    chk("wr_mem_updated", 32'(mem[0][idx(16'h4000)]), 32'hBEEF);
    push(0, 1'b0, 1'b1, 16'hBEEF);
    cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 16'h4000;
    drain(0, 10);
    chk("rb_cpu_rdata", 32'(cpu_rdata[0]), 32'hBEEF);

    // Round-robin with both ports held after reset.
    pulse_reset();
    chk("rr_rst_rdata", 32'(cpu_rdata[0]), 0);
    hold_cpu[0] = 1; hold_dbg[0] = 1;
    push(0, 1'b0, 1'b1, 16'h1234);
    push(0, 1'b1, 1'b1, 16'hBEEF);
    push(0, 1'b0, 1'b1, 16'h1234);
    push(0, 1'b1, 1'b1, 16'hBEEF);
    cpu_addr[0] = 16'h3000; cpu_we[0] = 0; cpu_req[0] = 1;
    dbg_addr[0] = 16'h4000; dbg_we[0] = 0; dbg_req[0] = 1;
    t_prev = cyc;
    for (int n = 0; n < 4; n++) begin
      wait_ready(0, 10);
      if (n > 0) chk("rr_period", cyc - t_prev, 4);
      t_prev = cyc;
    end
    cpu_req[0] = 0; dbg_req[0] = 0; hold_cpu[0] = 0; hold_dbg[0] = 0;
    chk("rr_all_scored", pending(0), 0);

    // Debug priority on instance 1.
    hold_cpu[1] = 1; hold_dbg[1] = 1;
    for (int n = 0; n < 3; n++) push(1, 1'b1, 1'b1, 16'h5555);
    push(1, 1'b0, 1'b1, 16'h1234);
    cpu_addr[1] = 16'h3000; cpu_we[1] = 0; cpu_req[1] = 1;
    dbg_addr[1] = 16'h4000; dbg_we[1] = 0; dbg_req[1] = 1;
    for (int n = 0; n < 3; n++) wait_ready(1, 10);
    t_prev = cyc;
    dbg_req[1] = 0; hold_dbg[1] = 0; hold_cpu[1] = 0;
    wait_ready(1, 10);
    chk("prio_cpu_next_idle", cyc - t_prev, 4);
    chk("prio_cpu_ready", 32'(cpu_ready[1]), 1);
    drain(1, 10);

    // Reset during the second ACCESS cycle of a CPU read.
    step();
    cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 16'h3000;
    step();
    step();
    chk("rst_mid_mem_en_before", 32'(mem_en[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_mem_en", 32'(mem_en[0]), 0);
    chk("rst_mid_grant", 32'(grant[0]), 0);
    chk("rst_mid_rdata", 32'(cpu_rdata[0]), 0);
    cpu_req[0] = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 4; n++) step();
    chk("rst_mid_no_ready", 32'(cpu_ready[0]), 0);

    // MEM_LAT=1 write with req withdrawn during ACCESS.
    push(2, 1'b0, 1'b0, 16'h0000);
    cpu_req[2] = 1; cpu_we[2] = 1; cpu_addr[2] = 16'h5000; cpu_wdata[2] = 16'h7777;
    step();
    chk("l1_c1_en_we", 32'({mem_en[2], mem_we[2]}), 32'h3);
    cpu_req[2] = 0;
    step();
    chk("l1_c2_mem_en", 32'(mem_en[2]), 0);
    chk("l1_c2_ready", 32'(cpu_ready[2]), 1);
    step();
    chk("l1_c3_ready", 32'(cpu_ready[2]), 0);
    chk("l1_mem_updated", 32'(mem[2][idx(16'h5000)]), 32'h7777);

    step();
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
Two-port arbiter and access sequencer for the single LC-3 memory array. It shares the array between the CPU memory path (the MAR/MDR side driven by MIO.EN and R.W) and a debug/program-loader port. It grants one requester at a time and holds the access stable for MEM_LAT cycles. It then returns a one-cycle ready pulse with registered read data, which gives the CPU state machine its READY signal.

Parameters:
MEM_LAT, 2, cycles mem_en/addr/we are held per access (legal range 1..15).
DBG_PRIO, 0, 0 = round-robin between ports; 1 = debug port wins every simultaneous request.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
cpu_req  in  1  CPU access request; held until cpu_ready.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  16  CPU word address.
cpu_wdata  in  16  CPU write data.
cpu_ready  out  1  one-cycle completion pulse to the CPU.
cpu_rdata  out  16  CPU read data; valid while cpu_ready=1, held until the next CPU completion.
dbg_req  in  1  debug access request; held until dbg_ready.
dbg_we  in  1  1 = write.
dbg_addr  in  16  debug word address.
dbg_wdata  in  16  debug write data.
dbg_ready  out  1  one-cycle completion pulse to the debug port.
dbg_rdata  out  16  debug read data; same rules as cpu_rdata.
mem_en  out  1  memory enable, high for exactly MEM_LAT cycles per access.
mem_we  out  1  write enable, qualified by mem_en.
mem_addr  out  16  memory address, stable while mem_en=1.
mem_wdata  out  16  memory write data, stable while mem_en=1.
mem_rdata  in  16  memory read data, valid in the last mem_en cycle.
grant  out  2  one-hot owner: 01 = CPU, 10 = debug, 00 = none.

Behaviour:
- All outputs are registered. Reset clears every output to 0, sets state to IDLE, counter to 0, and last_grant to DBG, so the CPU wins the first tie.
- FSM states are IDLE, ACCESS and RESP.
- IDLE: if any req is sampled high, pick the winner and latch its we/addr/wdata. Next cycle mem_en=1, grant=winner, cnt=MEM_LAT-1, state goes to ACCESS. If no req, stay in IDLE.
- Winner selection: if only one port requests, it wins. If both request, DBG_PRIO=1 gives debug. Otherwise (round-robin) the port opposite last_grant wins. last_grant updates on grant.
- ACCESS: mem_* outputs come from the latched registers. cnt decrements each cycle. When cnt==0:
  - capture mem_rdata into the owner's rdata register;
  - next cycle mem_en=0, mem_we=0, owner's ready=1, state goes to RESP.
- RESP: one cycle with ready high and grant still held. Then state returns to IDLE, ready=0, grant=00.
- Latency: req sampled at edge 0 gives mem_en high during cycles 1..MEM_LAT and ready high during cycle MEM_LAT+1. Peak throughput is one access per MEM_LAT+2 cycles.
- Write data is valid on every mem_en&mem_we cycle. Repeated commits of the same data are idempotent.
- Requesters must drop or change req the cycle after ready. A req still high in IDLE is treated as a new access.
- A req or other input that changes during ACCESS is ignored, because the access uses latched values. A granted access always completes and pulses ready even if its req was withdrawn. There is no abort.
- The losing requester stays pending with no timeout. Under DBG_PRIO=1 a continuous debug stream can starve the CPU; this is intended for halt/load use.
- Reset asserted mid-ACCESS or mid-RESP: mem_en, ready and grant drop immediately (asynchronously). The access is discarded and a partial write is not guaranteed. rdata registers clear to 0.
- The counter is 4 bits wide. MEM_LAT=1 means a single ACCESS cycle with cnt==0 on entry.

Decomposition:
- Package lc3_mem_arb_pkg holds:
  - the state enum (IDLE/ACCESS/RESP);
  - grant encodings GRANT_NONE=2'b00, GRANT_CPU=2'b01, GRANT_DBG=2'b10;
  - counter width CNT_W=4.
- One sub-module, lc3_rr_arb2: combinational 2-way pick from req[1:0], last_grant and DBG_PRIO, producing a one-hot winner.
- The FSM, latches and ready/rdata registers stay in lc3_mem_arbiter.

Test Plan:
- MEM_LAT=2; memory holds 0x1234 at 0x3000. CPU reads 0x3000 -> mem_en high for cycles 1-2 with mem_addr=0x3000; cpu_ready high in cycle 3 with cpu_rdata=0x1234; dbg_ready stays 0.
- Debug writes 0xBEEF to 0x4000, then the CPU reads 0x4000 -> mem_we=1 for 2 cycles, dbg_ready pulses once, then cpu_rdata=0xBEEF.
- After reset, both ports hold req continuously with DBG_PRIO=0 -> grants go CPU, DBG, CPU, DBG, with ready pulses every 4 cycles alternating ports.
- DBG_PRIO=1 with both ports requesting -> debug is granted every time. When dbg_req drops, the CPU is granted in the next IDLE.
- rst pulsed in the 2nd ACCESS cycle of a CPU read -> mem_en=0 and grant=00 immediately; no cpu_ready; cpu_rdata=0.
- MEM_LAT=1: CPU write, then cpu_req dropped during ACCESS -> mem_en high for exactly 1 cycle, cpu_ready still pulses, memory is updated.
